// File: rtl/lisp_pkg.sv
// Shared types and constants for the evaluator memory subsystem.
package lisp_pkg;

   localparam int ADDR_W = 12;
   localparam int WORD_W = 16;

   typedef logic [ADDR_W-1:0] address_t;
   typedef logic [WORD_W-1:0] word_t;
   typedef logic [1:0]        tag_t;

   // Response word returned when the memory never answers.
   localparam word_t TIMEOUT_ERROR = 16'hEEEE;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT,
      ARB_RESP
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Round-robin winner search: first asserted request after last_grant, wrapping.
module rr_arbiter
   import lisp_pkg::*;
#(
   parameter int N_REQ = 3
) (
   input  logic [N_REQ-1:0] req,
   input  tag_t             last_grant,
   output logic             valid,
   output tag_t             winner
);

   int idx;

   // Walk the ring starting just past the previous winner; the first hit wins.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int off = 1; off <= N_REQ; off++) begin
         idx = (int'(last_grant) + off) % N_REQ;
         if (!valid && req[idx]) begin
            valid  = 1'b1;
            winner = tag_t'(idx);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter: grants one requester at a time, forwards
// the latched request downstream and returns the response or a timeout error.
module mem_arbiter
   import lisp_pkg::*;
#(
   parameter int N_REQ   = 3,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req,
   input  logic [N_REQ-1:0]      we,
   input  logic [N_REQ*12-1:0]   addr,
   input  logic [N_REQ*16-1:0]   wdata,
   output logic [N_REQ-1:0]      ready,
   output logic [15:0]           rdata,
   output logic                  err,
   output logic                  busy,
   output logic [1:0]            grant,
   output logic                  timeout_seen,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [11:0]           mem_addr,
   output logic [15:0]           mem_wdata,
   input  logic                  mem_ready,
   input  logic [15:0]           mem_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   arb_state_t       state_q, state_d;
   tag_t             grant_q, grant_d;
   tag_t             last_grant_q, last_grant_d;
   logic             mem_we_q, mem_we_d;
   address_t         mem_addr_q, mem_addr_d;
   word_t            mem_wdata_q, mem_wdata_d;
   word_t            rdata_q, rdata_d;
   logic             err_q, err_d;
   logic             timeout_seen_q, timeout_seen_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             arb_valid;
   tag_t             arb_winner;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req        (req),
      .last_grant (last_grant_q),
      .valid      (arb_valid),
      .winner     (arb_winner)
   );

   // Next-state logic; the winner's request is captured only on leaving IDLE.
   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      last_grant_d   = last_grant_q;
      mem_we_d       = mem_we_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      rdata_d        = rdata_q;
      err_d          = err_q;
      timeout_seen_d = timeout_seen_q;
      cnt_d          = cnt_q;
      case (state_q)
         ARB_IDLE: begin
            if (arb_valid) begin
               state_d     = ARB_ISSUE;
               grant_d     = arb_winner;
               mem_we_d    = we[arb_winner];
               mem_addr_d  = addr[int'(arb_winner)*ADDR_W +: ADDR_W];
               mem_wdata_d = wdata[int'(arb_winner)*WORD_W +: WORD_W];
            end
         end
         ARB_ISSUE: begin
            state_d = ARB_WAIT;
            cnt_d   = '0;
         end
         ARB_WAIT: begin
            if (mem_ready) begin
               state_d = ARB_RESP;
               rdata_d = mem_rdata;
               err_d   = 1'b0;
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               state_d        = ARB_RESP;
               rdata_d        = TIMEOUT_ERROR;
               err_d          = 1'b1;
               timeout_seen_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ARB_RESP: begin
            state_d      = ARB_IDLE;
            last_grant_d = grant_q;
            err_d        = 1'b0;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ARB_IDLE;
         grant_q        <= '0;
         last_grant_q   <= tag_t'(N_REQ - 1);
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         rdata_q        <= '0;
         err_q          <= 1'b0;
         timeout_seen_q <= 1'b0;
         cnt_q          <= '0;
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         last_grant_q   <= last_grant_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         rdata_q        <= rdata_d;
         err_q          <= err_d;
         timeout_seen_q <= timeout_seen_d;
         cnt_q          <= cnt_d;
      end
   end

   // Completion pulse goes only to the granted requester, only in RESP.
   always_comb begin
      ready = '0;
      if (state_q == ARB_RESP) begin
         ready[grant_q] = 1'b1;
      end
   end

   assign err          = (state_q == ARB_RESP) && err_q;
   assign busy         = (state_q != ARB_IDLE);
   assign grant        = grant_q;
   assign rdata        = rdata_q;
   assign timeout_seen = timeout_seen_q;
   assign mem_req      = (state_q == ARB_ISSUE);
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected transactions,
// monitors pop and compare on mem_req and on ready pulses.
module tb_mem_arbiter;

   localparam int N = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [N-1:0]  we;
   logic [N*12-1:0] addr;
   logic [N*16-1:0] wdata;
   logic [N-1:0]  ready;
   logic [15:0]   rdata;
   logic          err;
   logic          busy;
   logic [1:0]    grant;
   logic          timeout_seen;
   logic          mem_req;
   logic          mem_we;
   logic [11:0]   mem_addr;
   logic [15:0]   mem_wdata;
   logic          mem_ready;
   logic [15:0]   mem_rdata;

   logic          mem_ready_m;
   logic          force_ready;
   int            mem_lat;
   int            cyc;
   int            checks;
   int            failures;
   logic          prev_mem_req;

   typedef struct {
      int          idx;
      logic [11:0] addr;
      logic        we;
      logic [15:0] wdata;
      logic [15:0] rdata;
      logic        err;
   } exp_t;

   exp_t iss_q[$];
   exp_t rsp_q[$];

   assign mem_ready = mem_ready_m | force_ready;

   mem_arbiter #(.N_REQ(N), .TIMEOUT(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .we           (we),
      .addr         (addr),
      .wdata        (wdata),
      .ready        (ready),
      .rdata        (rdata),
      .err          (err),
      .busy         (busy),
      .grant        (grant),
      .timeout_seen (timeout_seen),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata)
   );

   // Free-running clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t mkExp(input int idx, input logic [11:0] a, input logic w,
                                  input logic [15:0] wd, input logic [15:0] rd, input logic e);
      exp_t x;
      x.idx = idx; x.addr = a; x.we = w; x.wdata = wd; x.rdata = rd; x.err = e;
      return x;
   endfunction

   // Memory model: answers mem_lat cycles after mem_req with 16'h1224 + address.
   initial begin
      logic [11:0] cap;
      int          lat;
      mem_ready_m = 1'b0;
      mem_rdata   = '0;
      forever begin
         @(negedge clk);
         if (mem_req && mem_lat > 0) begin
            cap = mem_addr;
            lat = mem_lat;
            repeat (lat) @(negedge clk);
            mem_ready_m = 1'b1;
            mem_rdata   = 16'h1224 + {4'h0, cap};
            @(negedge clk);
            mem_ready_m = 1'b0;
         end
      end
   end

   // Issue monitor: downstream request fields against the expected transaction.
   initial begin
      exp_t e;
      prev_mem_req = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            checkOutput("mem_req_single_cycle", {31'd0, prev_mem_req}, 32'd0);
            if (iss_q.size() == 0) begin
               checkOutput("unexpected_mem_req", 32'd1, 32'd0);
            end else begin
               e = iss_q.pop_front();
               checkOutput("mem_addr", {20'd0, mem_addr}, {20'd0, e.addr});
               checkOutput("mem_we", {31'd0, mem_we}, {31'd0, e.we});
               checkOutput("mem_wdata", {16'd0, mem_wdata}, {16'd0, e.wdata});
            end
         end
         prev_mem_req = mem_req;
      end
   end

   // Response monitor: every ready pulse must match the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (ready != '0) begin
            if (rsp_q.size() == 0) begin
               checkOutput("unexpected_ready", {29'd0, ready}, 32'd0);
            end else begin
               e = rsp_q.pop_front();
               checkOutput("ready_onehot", {29'd0, ready}, 32'd1 << e.idx);
               checkOutput("grant", {30'd0, grant}, e.idx);
               checkOutput("rdata", {16'd0, rdata}, {16'd0, e.rdata});
               checkOutput("err", {31'd0, err}, {31'd0, e.err});
               checkOutput("mem_addr_held", {20'd0, mem_addr}, {20'd0, e.addr});
            end
         end
      end
   end

   task automatic waitReady(input int idx, output int at);
      at = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (ready[idx]) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) checkOutput("ready_wait_expired", 32'd0, 32'd1);
   endtask

   task automatic applyStimulus(input int idx, input logic w, input logic [11:0] a,
                                input logic [15:0] wd, input int lat,
                                input logic [15:0] rd, input logic e);
      int at;
      mem_lat = lat;
      iss_q.push_back(mkExp(idx, a, w, wd, rd, e));
      rsp_q.push_back(mkExp(idx, a, w, wd, rd, e));
      @(negedge clk);
      req[idx]             = 1'b1;
      we[idx]              = w;
      addr[idx*12 +: 12]   = a;
      wdata[idx*16 +: 16]  = wd;
      waitReady(idx, at);
      req[idx] = 1'b0;
      we[idx]  = 1'b0;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_ready"}, {29'd0, ready}, 32'd0);
      checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, "_grant"}, {30'd0, grant}, 32'd0);
      checkOutput({tag, "_timeout_seen"}, {31'd0, timeout_seen}, 32'd0);
      checkOutput({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
      checkOutput({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      checkOutput({tag, "_mem_addr"}, {20'd0, mem_addr}, 32'd0);
      checkOutput({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
      checkOutput({tag, "_rdata"}, {16'd0, rdata}, 32'd0);
   endtask

   // Directed scenarios.
   initial begin
      int at;
      int last_at;
      cyc = 0; checks = 0; failures = 0;
      rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
      mem_lat = 1; force_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkResetState("reset");

      // Single read with two-cycle memory.
      applyStimulus(0, 1'b0, 12'h010, 16'h0000, 2, 16'h1234, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("busy_after_read", {31'd0, busy}, 32'd0);

      // Write from requester 2.
      applyStimulus(2, 1'b1, 12'h0FF, 16'h1005, 1, 16'h1323, 1'b0);

      // Contention: all three held, zero-wait memory, grants 0,1,2,0.
      mem_lat = 1;
      iss_q.push_back(mkExp(0, 12'h100, 1'b0, 16'h0, 16'h1324, 1'b0));
      iss_q.push_back(mkExp(1, 12'h200, 1'b0, 16'h0, 16'h1424, 1'b0));
      iss_q.push_back(mkExp(2, 12'h300, 1'b0, 16'h0, 16'h1524, 1'b0));
      iss_q.push_back(mkExp(0, 12'h100, 1'b0, 16'h0, 16'h1324, 1'b0));
      foreach (iss_q[i]) rsp_q.push_back(iss_q[i]);
      @(negedge clk);
      addr  = {12'h300, 12'h200, 12'h100};
      wdata = '0;
      req   = 3'b111;
      last_at = 0;
      for (int g = 0; g < 4; g++) begin
         waitReady(g % 3, at);
         if (g > 0) checkOutput("grant_spacing", at - last_at, 32'd4);
         last_at = at;
      end
      req = '0;

      // Requester input changes while its transaction is in flight.
      mem_lat = 2;
      iss_q.push_back(mkExp(1, 12'h020, 1'b0, 16'h0, 16'h1244, 1'b0));
      rsp_q.push_back(mkExp(1, 12'h020, 1'b0, 16'h0, 16'h1244, 1'b0));
      @(negedge clk);
      req[1] = 1'b1; addr[12 +: 12] = 12'h020;
      @(negedge clk);
      addr[12 +: 12] = 12'h030;
      waitReady(1, at);
      req[1] = 1'b0;

      // Timeout, then a normal transaction with the sticky flag still set.
      applyStimulus(0, 1'b0, 12'h0A0, 16'h0000, -1, 16'hEEEE, 1'b1);
      @(negedge clk);
      checkOutput("timeout_seen_set", {31'd0, timeout_seen}, 32'd1);
      applyStimulus(1, 1'b0, 12'h005, 16'h0000, 1, 16'h1229, 1'b0);
      checkOutput("timeout_seen_sticky", {31'd0, timeout_seen}, 32'd1);

      // Reset while waiting on memory, then a late mem_ready.
      mem_lat = -1;
      iss_q.push_back(mkExp(0, 12'h077, 1'b0, 16'h0, 16'h0, 1'b0));
      @(negedge clk);
      req[0] = 1'b1; addr[0 +: 12] = 12'h077;
      repeat (2) @(negedge clk);
      rst = 1'b1; req = '0;
      @(negedge clk);
      rst = 1'b0; force_ready = 1'b1;
      @(negedge clk);
      force_ready = 1'b0;
      repeat (3) @(negedge clk);
      checkResetState("reset_in_wait");

      // Priority restarts at index 0 after reset.
      mem_lat = 1;
      iss_q.push_back(mkExp(0, 12'h040, 1'b0, 16'h0, 16'h1264, 1'b0));
      iss_q.push_back(mkExp(1, 12'h050, 1'b0, 16'h0, 16'h1274, 1'b0));
      rsp_q.push_back(mkExp(0, 12'h040, 1'b0, 16'h0, 16'h1264, 1'b0));
      rsp_q.push_back(mkExp(1, 12'h050, 1'b0, 16'h0, 16'h1274, 1'b0));
      @(negedge clk);
      addr[0 +: 12] = 12'h040; addr[12 +: 12] = 12'h050;
      req = 3'b011;
      waitReady(0, at);
      req[0] = 1'b0;
      waitReady(1, at);
      req[1] = 1'b0;

      repeat (4) @(negedge clk);
      checkOutput("issue_queue_drained", iss_q.size(), 32'd0);
      checkOutput("response_queue_drained", rsp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N_REQ, default 3, number of requester ports (index 0 = evaluator core).
REQ-002 Parameter TIMEOUT, default 255, maximum cycles in WAIT before a transaction is aborted.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req  input  N_REQ  per-requester request, held high until that requester's ready pulse.
REQ-006 we  input  N_REQ  per-requester write enable (0 = read), valid while req is high.
REQ-007 addr  input  N_REQ x 12  per-requester word address (address_t).
REQ-008 wdata  input  N_REQ x 16  per-requester write word.
REQ-009 ready  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-010 rdata  output  16  response word, valid in the cycle ready is high; shared by all requesters.
REQ-011 err  output  1  high with ready when the transaction timed out.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 grant  output  2  index of the current or last granted requester.
REQ-014 timeout_seen  output  1  sticky flag, set on any timeout, cleared only by rst.
REQ-015 mem_req, mem_we  output  1 each; mem_addr  output  12; mem_wdata  output  16  downstream memory request.
REQ-016 mem_ready  input  1; mem_rdata  input  16  downstream memory completion and data.

Function
REQ-017 The FSM SHALL have exactly four states, IDLE, ISSUE, WAIT and RESP, and exactly one transaction SHALL be outstanding at a time.
- IDLE -> ISSUE when any req bit is high.
- ISSUE -> WAIT unconditionally.
- WAIT -> RESP on mem_ready or timeout.
- RESP -> IDLE unconditionally.
REQ-018 In IDLE, the winner SHALL be the first asserted req bit, searching from index (last_grant+1) mod N_REQ and wrapping around (round-robin). After reset, last_grant = N_REQ-1, so index 0 has priority first.
REQ-019 On the IDLE->ISSUE edge, the arbiter SHALL latch the winner's index, we, addr and wdata. Requester inputs changing afterwards SHALL NOT affect the transaction.
REQ-020 mem_req SHALL be high for exactly one cycle (ISSUE), with the latched mem_addr, mem_we and mem_wdata. mem_addr, mem_we and mem_wdata SHALL hold their values until RESP.
REQ-021 In WAIT, a cycle counter SHALL start at 0 and increment each cycle. mem_ready observed in WAIT SHALL latch mem_rdata into rdata and move the FSM to RESP with err=0.
REQ-022 If the counter reaches TIMEOUT without mem_ready, the FSM SHALL go to RESP with err=1, rdata=16'hEEEE (TIMEOUT_ERROR), and timeout_seen set. If mem_ready arrives in the same cycle, mem_ready wins.
REQ-023 In RESP, ready[grant] SHALL be 1 for that single cycle, all other ready bits 0, and last_grant SHALL update to grant.
REQ-024 Minimum latency: req sampled in IDLE at cycle T, ISSUE at T+1, earliest mem_ready at T+2, ready at T+3. Back-to-back grants SHALL be separated by one IDLE cycle.
REQ-025 mem_ready received in IDLE, ISSUE or RESP SHALL be ignored.
REQ-026 A requester dropping req after being granted SHALL NOT cancel the transaction; its ready pulse is still issued.
REQ-027 Write completion SHALL return mem_rdata on rdata, the same as a read.
REQ-028 Outside RESP, rdata SHALL hold its last value and err SHALL be 0.

Reset
REQ-029 On rst, the block SHALL be in state IDLE with:
- ready=0, err=0, busy=0, grant=0, timeout_seen=0
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
- rdata=0, counter=0, last_grant=N_REQ-1
REQ-030 rst asserted mid-transaction SHALL abandon it with no ready pulse. A late mem_ready after reset SHALL be ignored (REQ-025).

Structure
REQ-031 address_t (12-bit), the 16-bit word width, tag_t, TIMEOUT_ERROR (16'hEEEE) and the arbiter state enum SHALL live in the shared package lisp_pkg.
REQ-032 The round-robin winner search SHALL be a combinational sub-module rr_arbiter (inputs req and last_grant; outputs valid and winner index). All remaining logic stays in mem_arbiter.

Verification
REQ-033 Single read: req[0]=1, addr=12'h010, memory returns 16'h1234 two cycles after mem_req. Required: mem_req one cycle with addr 12'h010, ready[0] pulse with rdata=16'h1234 and err=0, busy low afterwards.
REQ-034 Contention: req=3'b111 held continuously, zero-wait memory. Required: grant sequence 0,1,2,0, each ready pulse one cycle, 4 cycles per grant.
REQ-035 Write: req[2]=1, we[2]=1, addr=12'h0FF, wdata=16'h1005. Required: mem_we=1, mem_addr=12'h0FF, mem_wdata=16'h1005 during ISSUE, then ready[2] pulse.
REQ-036 Timeout: TIMEOUT=8 and memory never responds. Required: ready pulse with err=1, rdata=16'hEEEE and timeout_seen=1; the next request completes normally with timeout_seen still 1.
REQ-037 Reset in WAIT: assert rst, then assert mem_ready one cycle later. Required: no ready pulse, state IDLE, outputs at their REQ-029 values.
REQ-038 Input change after grant: change addr[1] from 12'h020 to 12'h030 one cycle after IDLE->ISSUE. Required: mem_addr stays 12'h020 through RESP.
